// File: rtl/qu_decode_stage.sv
// Registered RV32I decode stage: classifies the instruction, extracts register/function
// fields and rebuilds the immediate. Define QU_DECODE_ILLEGAL_CHECK_EN to enable out_illegal.
module qu_decode_stage #(
    parameter int QU_PC_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [QU_PC_W-1:0] in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_class,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic [31:0]        out_imm,
    output logic [QU_PC_W-1:0] out_pc,
    output logic               out_illegal
);

    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_IALU   = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;
    localparam logic [3:0] CLS_SYSTEM = 4'd9;
    localparam logic [3:0] CLS_FENCE  = 4'd10;
    localparam logic [3:0] CLS_INV    = 4'd15;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  dec_class;
    logic [31:0] dec_imm;
    logic        load_en;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Handshake: a transfer happens on a side when valid && ready are both high at
    // the rising edge; out_* stay stable while out_valid && !out_ready.
    assign in_ready = !out_valid || out_ready;
    assign load_en  = in_valid && in_ready && !flush;

    always_comb begin
        dec_class = CLS_INV;
        dec_imm   = 32'd0;
        case (opcode)
            7'b0110011: dec_class = CLS_R;
            7'b0010011: begin
                dec_class = CLS_IALU;
                dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0000011: begin
                dec_class = CLS_LOAD;
                dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_class = CLS_STORE;
                dec_imm   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_class = CLS_BRANCH;
                dec_imm   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_class = CLS_JAL;
                dec_imm   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                dec_class = CLS_JALR;
                dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0110111: begin
                dec_class = CLS_LUI;
                dec_imm   = {in_instr[31:12], 12'd0};
            end
            7'b0010111: begin
                dec_class = CLS_AUIPC;
                dec_imm   = {in_instr[31:12], 12'd0};
            end
            7'b1110011: begin
                dec_class = CLS_SYSTEM;
                dec_imm   = {20'd0, in_instr[31:20]};
            end
            7'b0001111: dec_class = CLS_FENCE;
            default:    dec_class = CLS_INV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_class  <= CLS_INV;
            out_rd     <= 5'd0;
            out_rs1    <= 5'd0;
            out_rs2    <= 5'd0;
            out_funct3 <= 3'd0;
            out_funct7 <= 7'd0;
            out_imm    <= 32'd0;
            out_pc     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            out_valid  <= 1'b1;
            out_class  <= dec_class;
            out_rd     <= in_instr[11:7];
            out_rs1    <= in_instr[19:15];
            out_rs2    <= in_instr[24:20];
            out_funct3 <= f3;
            out_funct7 <= f7;
            out_imm    <= dec_imm;
            out_pc     <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef QU_DECODE_ILLEGAL_CHECK_EN
    logic dec_illegal;

    always_comb begin
        dec_illegal = 1'b0;
        case (dec_class)
            CLS_R: dec_illegal = !((f7 == 7'b0000000) ||
                                   (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            CLS_IALU: begin
                if (f3 == 3'b001)
                    dec_illegal = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    dec_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            CLS_LOAD:   dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            CLS_STORE:  dec_illegal = (f3 > 3'b010);
            CLS_BRANCH: dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
            CLS_JALR:   dec_illegal = (f3 != 3'b000);
            // Only ECALL (imm 0) and EBREAK (imm 1) are valid with funct3 000.
            CLS_SYSTEM: dec_illegal = (f3 == 3'b100) ||
                                      (f3 == 3'b000 && in_instr[31:20] > 12'd1);
            CLS_INV:    dec_illegal = 1'b1;
            default:    dec_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_illegal <= 1'b0;
        else if (load_en)
            out_illegal <= dec_illegal;
    end
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_qu_decode_stage.sv
// Directed bench for qu_decode_stage: decode table, stall, flush and reset scenarios.
module tb_qu_decode_stage;

    localparam int PC_W = 12;
    localparam int NV   = 18;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_class;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [31:0]     out_imm;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-decoded vectors: instruction, class, rd, immediate, illegal when checking is on.
    logic [31:0] v_instr [NV] = '{
        32'h002081B3, 32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h00000000,
        32'hFE112E23, 32'hFFDFF06F, 32'h00001517, 32'hFFC08067, 32'h00412083,
        32'hF1402573, 32'h0FF0000F, 32'h402091B3, 32'h0000B083, 32'h00000073,
        32'h00200073, 32'h4000D093, 32'h40009093};
    logic [3:0]  v_class [NV] = '{
        4'd0, 4'd1, 4'd4, 4'd7, 4'd15, 4'd3, 4'd5, 4'd8, 4'd6, 4'd2,
        4'd9, 4'd10, 4'd0, 4'd2, 4'd9, 4'd9, 4'd1, 4'd1};
    logic [4:0]  v_rd [NV] = '{
        5'd3, 5'd1, 5'd29, 5'd5, 5'd0, 5'd28, 5'd0, 5'd10, 5'd0, 5'd1,
        5'd10, 5'd0, 5'd3, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
    logic [31:0] v_imm [NV] = '{
        32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000000,
        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00001000, 32'hFFFFFFFC, 32'h00000004,
        32'h00000F14, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000002, 32'h00000400, 32'h00000400};
    logic        v_ill [NV] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    qu_decode_stage #(.QU_PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct3 (out_funct3),
        .out_funct7 (out_funct7),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_class !== 4'd15 || out_illegal !== 1'b0 ||
            out_imm !== 32'd0 || out_pc !== '0 || out_rd !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_state: valid=%b class=%0d ill=%b imm=%h pc=%h rd=%0d, want 0/15/0/0/0/0",
                     out_valid, out_class, out_illegal, out_imm, out_pc, out_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins;
        logic        exp_ill;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            ins       = v_instr[i];
            in_valid  = 1'b1;
            in_instr  = ins;
            in_pc     = PC_W'(12'h400 + 4 * i);
            out_ready = 1'b1;
`ifdef QU_DECODE_ILLEGAL_CHECK_EN
            exp_ill = v_ill[i];
`else
            exp_ill = 1'b0;
`endif
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_class !== v_class[i] || out_rd !== v_rd[i] ||
                out_imm !== v_imm[i] || out_illegal !== exp_ill ||
                out_pc !== PC_W'(12'h400 + 4 * i)) begin
                n_errors++;
                $display("FAIL decode[%0d] %h: valid=%b class=%0d rd=%0d imm=%h ill=%b pc=%h, want 1/%0d/%0d/%h/%b/%h",
                         i, ins, out_valid, out_class, out_rd, out_imm, out_illegal, out_pc,
                         v_class[i], v_rd[i], v_imm[i], exp_ill, PC_W'(12'h400 + 4 * i));
            end
            n_checks++;
            if (out_rs1 !== ins[19:15] || out_rs2 !== ins[24:20] ||
                out_funct3 !== ins[14:12] || out_funct7 !== ins[31:25]) begin
                n_errors++;
                $display("FAIL fields[%0d]: rs1=%0d rs2=%0d f3=%0d f7=%h, want %0d/%0d/%0d/%h",
                         i, out_rs1, out_rs2, out_funct3, out_funct7,
                         ins[19:15], ins[24:20], ins[14:12], ins[31:25]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        in_pc     = 12'h100;
        out_ready = 1'b1;
        @(negedge clk);
        in_instr  = 32'h123452B7;
        in_pc     = 12'h104;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 12'h100 || out_class !== 4'd0 ||
                out_rd !== 5'd3 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h class=%0d rd=%0d in_ready=%b, want 1/100/0/3/0",
                         c, out_valid, out_pc, out_class, out_rd, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 12'h104 || out_class !== 4'd7 || out_rd !== 5'd5) begin
            n_errors++;
            $display("FAIL stall_next: valid=%b pc=%h class=%0d rd=%0d, want 1/104/7/5",
                     out_valid, out_pc, out_class, out_rd);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_no_dup: valid=%b pc=%h, want valid 0", out_valid, out_pc);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 12'h200;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 12'h200) begin
            n_errors++;
            $display("FAIL flush_load: valid=%b pc=%h, want 1/200", out_valid, out_pc);
        end
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h123452B7;
        in_pc     = 12'h204;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_clear: valid=%b pc=%h, want valid 0", out_valid, out_pc);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = 32'hFE000EE3;
        in_pc     = 12'h300;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_class !== 4'd4) begin
            n_errors++;
            $display("FAIL midrst_load: valid=%b class=%0d, want 1/4", out_valid, out_class);
        end
        @(negedge clk);
        in_instr = 32'h00412083;
        in_pc    = 12'h304;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_class !== 4'd15 || out_pc !== '0 || out_imm !== 32'd0) begin
            n_errors++;
            $display("FAIL midrst_async: valid=%b class=%0d pc=%h imm=%h, want 0/15/0/0",
                     out_valid, out_class, out_pc, out_imm);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_after: valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stall();
        test_flush();
        test_reset_midstream();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qu_decode_stage.md
QU_DECODE_STAGE -- requirements
Module: qu_decode_stage

Interface
REQ-001 SHALL have parameter QU_PC_W, default 12, width of the instruction PC carried alongside each instruction.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, which discards the held output instruction.
REQ-005 SHALL have port in_valid, input, 1, which qualifies in_instr and in_pc.
REQ-006 SHALL have port in_ready, output, 1, meaning the stage accepts an instruction this cycle.
REQ-007 SHALL have port in_instr, input, 32, the raw RV32I instruction word.
REQ-008 SHALL have port in_pc, input, QU_PC_W, the PC of in_instr.
REQ-009 SHALL have port out_valid, output, 1, which qualifies all out_* fields.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the output this cycle.
REQ-011 SHALL have port out_class, output, 4, the instruction class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE, 15 INVALID.
REQ-012 SHALL have ports out_rd, out_rs1 and out_rs2, output, 5 each, which carry the register fields.
REQ-013 SHALL have ports out_funct3 (output, 3) and out_funct7 (output, 7), which carry the raw function fields.
REQ-014 SHALL have port out_imm, output, 32, the reconstructed immediate.
REQ-015 SHALL have port out_pc, output, QU_PC_W, the PC of the held instruction.
REQ-016 SHALL have port out_illegal, output, 1, the illegal-instruction flag.

Function
REQ-017 SHALL be a single registered pipeline stage with 1-cycle latency: a transfer accepted at edge N appears on out_* after edge N.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (combinational), sustaining one instruction per cycle under continuous out_ready.
REQ-019 SHALL load the output register when in_valid && in_ready; otherwise it SHALL clear out_valid when out_ready is high, or hold all out_* stable when out_ready is low.
REQ-020 SHALL clear out_valid at the next edge when flush=1, ignoring any simultaneous in_valid.
REQ-021 SHALL form out_imm by instruction format:
- I/LOAD/JALR: sext(instr[31:20]).
- STORE: sext({instr[31:25], instr[11:7]}).
- BRANCH: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- LUI/AUIPC: {instr[31:12], 12'b0}.
- JAL: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- SYSTEM: zero-extended instr[31:20].
- R/FENCE/INVALID: 0.
REQ-022 SHALL pass out_rd, out_rs1, out_rs2, out_funct3 and out_funct7 from their fixed bit positions regardless of class.
REQ-023 SHALL set out_class=15 for any opcode not among the eleven RV32I opcodes.

Reset
REQ-024 SHALL, while rst_n=0, force out_valid=0, out_class=15, out_illegal=0 and all other out_* to 0, asynchronously.
REQ-025 SHALL discard any in-flight instruction when reset is asserted; in_ready SHALL be 1 from the first edge after rst_n rises.

Configuration
REQ-026 SHALL be controlled by macro QU_DECODE_ILLEGAL_CHECK_EN.
REQ-027 SHALL, when QU_DECODE_ILLEGAL_CHECK_EN is defined, set out_illegal=1 for any of the following:
- class 15.
- R with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101.
- SLLI with funct7≠0.
- SRLI/SRAI with funct7 not 0000000/0100000.
- LOAD funct3 in {011,110,111}.
- STORE funct3>010.
- BRANCH funct3 in {010,011}.
- JALR funct3≠000.
- SYSTEM funct3=100.
- SYSTEM funct3=000 with instr[31:20] not 0/1.
REQ-028 SHALL, when QU_DECODE_ILLEGAL_CHECK_EN is not defined, tie out_illegal to 0 and include no check logic; out_class decoding SHALL be unchanged.

Verification
REQ-029 SHALL cover: in_instr=0x002081B3 -> class 0, rd=3, rs1=1, rs2=2, imm=0, illegal=0, one cycle later.
REQ-030 SHALL cover: in_instr=0xFFF00093 -> class 1, rd=1, imm=0xFFFFFFFF.
REQ-031 SHALL cover: in_instr=0xFE000EE3 -> class 4, imm=0xFFFFFFFC; and in_instr=0x123452B7 -> class 7, rd=5, imm=0x12345000.
REQ-032 SHALL cover: in_instr=0x00000000 -> class 15, illegal=1 with macro defined, illegal=0 without it.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; then out_ready=1 -> next instruction appears, none lost or duplicated.
REQ-034 SHALL cover: flush=1 with in_valid=1 -> out_valid=0 next cycle; rst_n=0 mid-stream -> out_valid=0 immediately.
